// File: rtl/tt_sweep_checker.sv
// Exhaustive truth-table sweeper for a small combinational unit.
// Applies every input vector, samples the response and scores it.
module tt_sweep_checker #(
  parameter int                    N_IN     = 4,
  parameter logic [2**N_IN-1:0]    EXPECTED = 16'h7310,
  parameter int                    SETTLE   = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                dut_s,
  output logic [N_IN-1:0]     vec_out,
  output logic                busy,
  output logic                done,
  output logic [2**N_IN-1:0]  table_out,
  output logic [N_IN:0]       mismatch_cnt,
  output logic                fail_valid,
  output logic [N_IN-1:0]     first_fail_idx,
  output logic                pass
);

  localparam int NV = 2**N_IN;
  localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [N_IN-1:0] LAST = N_IN'(NV-1);
  localparam logic [SW-1:0]   SLST = SW'(SETTLE-1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_APPLY,
    S_DONE
  } state_t;

  state_t            r_state;
  logic [N_IN-1:0]   r_idx;
  logic [SW-1:0]     r_settle;
  logic              r_busy;
  logic              r_done;
  logic [NV-1:0]     r_table;
  logic [N_IN:0]     r_cnt;
  logic              r_fv;
  logic [N_IN-1:0]   r_ffi;
  logic              r_pass;

  logic              w_exp;
  logic              w_miss;
  logic [N_IN:0]     w_cnt_nxt;

  // X or Z on the response must count as a failure, hence the 4-state compare
  assign w_exp     = EXPECTED[r_idx];
  assign w_miss    = (dut_s !== w_exp);
  assign w_cnt_nxt = r_cnt + (N_IN+1)'(w_miss);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_idx    <= '0;
      r_settle <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_table  <= '0;
      r_cnt    <= '0;
      r_fv     <= 1'b0;
      r_ffi    <= '0;
      r_pass   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (start) begin
            r_table  <= '0;
            r_cnt    <= '0;
            r_fv     <= 1'b0;
            r_ffi    <= '0;
            r_pass   <= 1'b0;
            r_idx    <= '0;
            r_settle <= '0;
            r_busy   <= 1'b1;
            r_state  <= S_APPLY;
          end
        end
        S_APPLY: begin
          if (r_settle == SLST) begin
            r_table[r_idx] <= dut_s;
            r_settle       <= '0;
            if (w_miss) begin
              r_cnt <= w_cnt_nxt;
              if (!r_fv) begin
                r_fv  <= 1'b1;
                r_ffi <= r_idx;
              end
            end
            if (r_idx == LAST) begin
              r_busy  <= 1'b0;
              r_pass  <= (w_cnt_nxt == '0);
              r_state <= S_DONE;
            end else begin
              r_idx <= r_idx + 1'b1;
            end
          end else begin
            r_settle <= r_settle + 1'b1;
          end
        end
        S_DONE: begin
          r_done  <= 1'b1;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign vec_out        = r_idx;
  assign busy           = r_busy;
  assign done           = r_done;
  assign table_out      = r_table;
  assign mismatch_cnt   = r_cnt;
  assign fail_valid     = r_fv;
  assign first_fail_idx = r_ffi;
  assign pass           = r_pass;

endmodule
